uart_frame_tx: RTL and testbench

- Parametrised multi-byte frame serializer between a wide data producer (cipher core, sequencer) and the byte-level UART transmitter.
- Latches an NBYTES-wide word on a strobe and feeds it to the byte UART one character at a time, MSB byte first.
- Two modes, selected per frame: raw binary bytes, or hex-ASCII (two uppercase characters per byte).
- Successor to the fixed 80-bit transmit path: width is generic and the nibble-splitting of the hex mode is explicit, not incidental.

---
 rtl/uart_pkg.sv | 17 +
 rtl/nibble_to_ascii.sv | 17 +
 rtl/uart_frame_tx.sv | 138 +++++++++++++
 tb/tb_uart_frame_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared state type and ASCII constants for the multi-byte UART frame transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StWaitIdle,
        StDone
    } state_e;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A_M10 = 8'h37;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit to uppercase hex-ASCII character converter.
module nibble_to_ascii
    import uart_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    always_comb begin
        if (i_nibble < 4'd10) begin
            o_ascii = ASCII_0 + {4'h0, i_nibble};
        end else begin
            o_ascii = ASCII_A_M10 + {4'h0, i_nibble};
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Serialises an NBYTES-wide word to a byte UART, MSB byte first, as raw bytes or hex-ASCII.
// Optional CR/LF terminator after every frame when UART_FRAME_TX_CRLF_EN is defined.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int unsigned NBYTES      = 10,
    parameter int unsigned HEX_DEFAULT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*NBYTES-1:0]   i_data,
    input  logic                  i_stb,
    input  logic                  i_hex,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [7:0]            o_byte,
    output logic                  o_byte_stb,
    input  logic                  i_tx_busy
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned CW = $clog2(2 * NBYTES + 3);
`ifdef UART_FRAME_TX_CRLF_EN
    localparam int unsigned NTERM = 2;
`else
    localparam int unsigned NTERM = 0;
`endif
    localparam logic [CW-1:0] NRAW = CW'(NBYTES + NTERM);
    localparam logic [CW-1:0] NHEX = CW'(2 * NBYTES + NTERM);

    if (NBYTES < 1 || NBYTES > 32 || HEX_DEFAULT > 1) begin : g_bad_param
        $error("uart_frame_tx: NBYTES must be 1..32 and HEX_DEFAULT 0 or 1");
    end

    state_e          state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hex_q, hex_d;
    logic [7:0]      byte_q, byte_d;
    logic            stb_q, stb_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [7:0]      hex_char;
    logic [7:0]      payload_char;
    logic [7:0]      cur_char;

    nibble_to_ascii u_nibble_to_ascii (
        .i_nibble (shift_q[W-1 -: 4]),
        .o_ascii  (hex_char)
    );

    assign payload_char = hex_q ? hex_char : shift_q[W-1 -: 8];

`ifdef UART_FRAME_TX_CRLF_EN
    // The last two counts of every frame carry the terminator.
    always_comb begin
        cur_char = payload_char;
        if (cnt_q == CW'(2)) begin
            cur_char = ASCII_CR;
        end else if (cnt_q == CW'(1)) begin
            cur_char = ASCII_LF;
        end
    end
`else
    assign cur_char = payload_char;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (i_stb) state_d = StIssue;
            StIssue:    if (!i_tx_busy) state_d = StWaitAck;
            StWaitAck:  if (i_tx_busy) state_d = StWaitIdle;
            StWaitIdle: if (!i_tx_busy) state_d = (cnt_q == CW'(1)) ? StDone : StIssue;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        byte_d  = byte_q;
        stb_d   = 1'b0;
        if (state_q == StIdle && i_stb) begin
            shift_d = i_data;
            hex_d   = i_hex;
            cnt_d   = i_hex ? NHEX : NRAW;
        end
        if (state_q == StIssue && !i_tx_busy) begin
            byte_d = cur_char;
            stb_d  = 1'b1;
        end
        if (state_q == StWaitIdle && !i_tx_busy) begin
            cnt_d   = cnt_q - CW'(1);
            shift_d = hex_q ? (shift_q << 4) : (shift_q << 8);
        end
        // Flags are registered from the next state so they line up with it.
        busy_d = state_d inside {StIssue, StWaitAck, StWaitIdle};
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            hex_q   <= 1'b0;
            byte_q  <= 8'h00;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            byte_q  <= byte_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_byte     = byte_q;
    assign o_byte_stb = stb_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: a 4-byte and a 1-byte instance, each with a byte-UART model.
module tb_uart_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_data;
    logic [7:0]  b_data;
    logic        a_stb, b_stb, i_hex;
    logic        a_busy, a_done, a_bstb, a_txb;
    logic        b_busy, b_done, b_bstb, b_txb;
    logic [7:0]  a_byte, b_byte;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          len_q[$];
    int          frames_exp = 0;
    int          done_cnt = 0;
    int          cur_chars = 0;
    bit          sel_b = 1'b0;
    bit          hold_busy = 1'b0;
    int          blen = 20;
    int          a_bcnt = 0, b_bcnt = 0;

    always #5 clk = ~clk;

    uart_frame_tx #(.NBYTES(4), .HEX_DEFAULT(0)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .i_data     (a_data),
        .i_stb      (a_stb),
        .i_hex      (i_hex),
        .o_busy     (a_busy),
        .o_done     (a_done),
        .o_byte     (a_byte),
        .o_byte_stb (a_bstb),
        .i_tx_busy  (a_txb)
    );

    uart_frame_tx #(.NBYTES(1), .HEX_DEFAULT(0)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .i_data     (b_data),
        .i_stb      (b_stb),
        .i_hex      (i_hex),
        .o_busy     (b_busy),
        .o_done     (b_done),
        .o_byte     (b_byte),
        .o_byte_stb (b_bstb),
        .i_tx_busy  (b_txb)
    );

    // Byte UART models: busy rises the cycle after the strobe and lasts blen cycles.
    always @(posedge clk) begin
        if (a_bstb) a_bcnt <= blen;
        else if (a_bcnt > 0) a_bcnt <= a_bcnt - 1;
        if (b_bstb) b_bcnt <= blen;
        else if (b_bcnt > 0) b_bcnt <= b_bcnt - 1;
    end
    assign a_txb = hold_busy || (a_bcnt > 0);
    assign b_txb = hold_busy || (b_bcnt > 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] hex_ascii(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    // Reference model: the character list a frame must produce.
    task automatic push_frame(input logic [255:0] d, input int nb, input bit hx);
        int len;
        int v;
        len = 0;
        for (int i = nb - 1; i >= 0; i--) begin
            v = int'(d[8*i +: 8]);
            if (hx) begin
                exp_q.push_back(hex_ascii(v / 16));
                exp_q.push_back(hex_ascii(v % 16));
                len += 2;
            end else begin
                exp_q.push_back(8'(v));
                len += 1;
            end
        end
`ifdef UART_FRAME_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        len += 2;
`endif
        len_q.push_back(len);
        frames_exp++;
    endtask

    always @(negedge clk) begin : monitor
        logic [7:0] mb;
        logic       ms, md, e;
        logic [7:0] ev;
        ms = sel_b ? b_bstb : a_bstb;
        md = sel_b ? b_done : a_done;
        mb = sel_b ? b_byte : a_byte;
        e  = sel_b ? (a_bstb | a_done) : (b_bstb | b_done);
        if (e) chk("idle_instance_activity", 32'(e), 32'd0);
        if (ms) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_char", 32'(mb), 32'hFFFF_FFFF);
            end else begin
                ev = exp_q.pop_front();
                chk("char", 32'(mb), 32'(ev));
            end
            cur_chars++;
        end
        if (md) begin
            done_cnt++;
            if (len_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("frame_len", 32'(cur_chars), 32'(len_q.pop_front()));
            end
            cur_chars = 0;
        end
    end

    task automatic send(input logic [31:0] d, input bit hx, input bit accept);
        @(posedge clk); #1;
        if (sel_b) begin b_data = d[7:0]; b_stb = 1'b1; end
        else begin a_data = d; a_stb = 1'b1; end
        i_hex = hx;
        if (accept) push_frame({224'd0, d}, sel_b ? 1 : 4, hx);
        @(posedge clk); #1;
        a_stb = 1'b0;
        b_stb = 1'b0;
        i_hex = 1'($urandom);
        a_data = $urandom;
        b_data = 8'($urandom);
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (done_cnt < frames_exp && n < bound) begin
            @(posedge clk);
            n++;
        end
        chk("done_within_bound", 32'(done_cnt >= frames_exp), 32'd1);
        chk("all_chars_consumed", 32'(exp_q.size()), 32'd0);
        done_cnt = frames_exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  saw;
        logic [31:0] d;

        rst = 1'b1; a_stb = 1'b0; b_stb = 1'b0; i_hex = 1'b0;
        a_data = '0; b_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'({a_busy, b_busy}), 32'd0);
        chk("reset_done", 32'({a_done, b_done}), 32'd0);
        chk("reset_byte", 32'({a_byte, b_byte}), 32'd0);
        chk("reset_stb", 32'({a_bstb, b_bstb}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Raw DEADBEEF, checking first-strobe latency.
        blen = 20;
        send(32'hDEADBEEF, 1'b0, 1'b1);
        @(negedge clk);
        chk("busy_after_accept", 32'(a_busy), 32'd1);
        chk("latency_early", 32'(a_bstb), 32'd0);
        @(negedge clk);
        chk("latency_first_stb", 32'(a_bstb), 32'd1);
        wait_done(400);

        // Hex 0012ABFF.
        send(32'h0012ABFF, 1'b1, 1'b1);
        wait_done(800);

        // A second request mid-frame must be dropped.
        send(32'hFAAF001F, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        send(32'h12345678, 1'b1, 1'b0);
        wait_done(400);

        // Strobe in the o_done cycle is ignored; the next cycle is accepted.
        blen = 3;
        send(32'hA5A55A5A, 1'b0, 1'b1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!a_done && n < 200);
        a_data = 32'h11111111; i_hex = 1'b0; a_stb = 1'b1;
        @(posedge clk); #1;
        a_data = 32'hC0FFEE42; i_hex = 1'b1;
        push_frame({224'd0, 32'hC0FFEE42}, 4, 1'b1);
        @(posedge clk); #1; a_stb = 1'b0;
        wait_done(400);

        // Reset during the third character of a hex frame.
        blen = 20;
        send(32'h9876FEDC, 1'b1, 1'b1);
        n = 0;
        while (cur_chars < 3 && n < 200) begin @(posedge clk); n++; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete(); len_q.delete(); frames_exp--; cur_chars = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_done", 32'(a_done), 32'd0);
        repeat (60) @(posedge clk);
        send(32'h3C4D5E6F, 1'b1, 1'b1);
        wait_done(800);

        // UART busy at acceptance: hold in ISSUE, strobe the cycle after busy falls.
        hold_busy = 1'b1;
        send(32'h01020304, 1'b0, 1'b1);
        saw = 1'b0;
        repeat (50) begin @(negedge clk); saw |= a_bstb; end
        chk("hold_no_stb", 32'(saw), 32'd0);
        @(posedge clk); #1 hold_busy = 1'b0;
        @(negedge clk);
        chk("release_same_cycle", 32'(a_bstb), 32'd0);
        @(negedge clk);
        chk("release_next_cycle", 32'(a_bstb), 32'd1);
        wait_done(400);

        // Randomised frames, some with an ignored mid-frame strobe.
        for (int k = 0; k < 25; k++) begin
            blen = $urandom_range(1, 12);
            d = $urandom;
            send(d, 1'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(3, 6)) @(posedge clk);
                send($urandom, 1'($urandom), 1'b0);
            end
            wait_done(800);
        end

        // Single-byte instance.
        repeat (30) @(posedge clk);
        sel_b = 1'b1;
        blen = 5;
        send(32'h5A, 1'b1, 1'b1);
        wait_done(300);
        send(32'h5A, 1'b0, 1'b1);
        wait_done(300);
        for (int k = 0; k < 8; k++) begin
            blen = $urandom_range(1, 10);
            send(32'($urandom_range(0, 255)), 1'($urandom), 1'b1);
            wait_done(300);
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
